fma_final_add: RTL
==================

FMA_FINAL_ADD -- requirements
Module: fma_final_add

Interface
REQ-001 SHALL have parameter SIG_WIDTH, default 23 from parameters.v; significand width without hidden bit; W = 2*(SIG_WIDTH+1)+5 = 53.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, an input beat is presented.
REQ-005 SHALL have port in_ready, output, 1, the block accepts the beat this cycle.
REQ-006 SHALL have port pp_sum, input, W, the sum vector from the partial-product reduction tree.
REQ-007 SHALL have port pp_carry, input, W, the carry vector from the same tree.
REQ-008 SHALL have port add_aligned, input, W, the addend significand, already aligned to the product.
REQ-009 SHALL have port eff_sub, input, 1, effective subtraction.
REQ-010 SHALL have port in_sticky, input, 1, the addend-shift sticky bit, passed through.
REQ-011 SHALL have port out_valid, output, 1, the result beat is valid.
REQ-012 SHALL have port out_ready, input, 1, the consumer accepts the beat.
REQ-013 SHALL have port res_mag, output, W, the magnitude of the result.
REQ-014 SHALL have port res_neg, output, 1, the result sign is flipped relative to the product.
REQ-015 SHALL have port res_zero, output, 1, res_mag equals 0.
REQ-016 SHALL have port res_lzc, output, 6, the leading-zero count of res_mag.
REQ-017 SHALL have port out_sticky, output, 1, in_sticky delayed along with its beat.

Function
REQ-018 SHALL compute P = (pp_sum + pp_carry) mod 2^W as unsigned.
REQ-019 SHALL compute S = {0,P} + (eff_sub ? -{0,add_aligned} : {0,add_aligned}) in 54-bit two's complement.
REQ-020 SHALL set res_neg = S[53], and res_mag = res_neg ? -S[52:0] : S[52:0].
REQ-021 SHALL set res_zero = (res_mag == 0); when res_zero=1, res_neg SHALL be 0.
REQ-022 SHALL set res_lzc to the number of leading zeros of res_mag (0..52), and to 53 when res_mag = 0.
REQ-023 SHALL have a two-stage pipeline: stage 1 is a 3:2 compression of P and the conditioned addend plus register; stage 2 is the carry-propagate add, negate, LZC and register.
REQ-024 SHALL have a latency of exactly 2 cycles from an accepted in_valid to out_valid when out_ready is held at 1.
REQ-025 SHALL sustain a throughput of one beat per cycle.
REQ-026 SHALL transfer a beat only on valid&ready, at both ports.
REQ-027 SHALL drive in_ready = !s1_valid | s1_advance, with s1_advance = !s2_valid | out_ready.
REQ-028 SHALL hold output data stable while out_valid=1 and out_ready=0, with no beat lost or duplicated.
REQ-029 SHALL, when both stages are full and out_ready=0, deassert in_ready combinationally in the same cycle.
REQ-030 SHALL allow a simultaneous input accept and output drain in one cycle, shifting the pipeline.
REQ-031 SHALL ignore data inputs when in_valid=0; stage registers SHALL then hold their values.

Reset
REQ-032 SHALL, on rst=1 at a clock edge, clear s1_valid and s2_valid, so that out_valid=0.
REQ-033 SHALL drive res_mag=0, res_neg=0, res_zero=1, res_lzc=53 and out_sticky=0 after reset.
REQ-034 SHALL, on rst asserted mid-operation, discard in-flight beats; in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-035 SHALL implement res_lzc and the lzc_53 instance when FMA_FINAL_LZC_EN is defined.
REQ-036 SHALL, without FMA_FINAL_LZC_EN, drive res_lzc constant 0 and omit the LZC logic; latency and handshake SHALL be unchanged.

Structure
REQ-037 SHALL take W, the LZC width (6) and the LZC zero code (53) as constants in parameters.v, shared with the multiplier stages.
REQ-038 SHALL implement the LZC as one sub-module, lzc_53 (53-bit input, 6-bit count), combinational and instantiated in stage 2.

Verification
REQ-039 SHALL cover: pp_sum=0x6, pp_carry=0x9, add_aligned=0x1, eff_sub=0 -> 2 cycles later res_mag=0x10, res_neg=0, res_lzc=48.
REQ-040 SHALL cover: pp_sum=0x5, pp_carry=0, add_aligned=0x8, eff_sub=1 -> res_mag=0x3, res_neg=1, res_zero=0.
REQ-041 SHALL cover: P=0x1234 and add_aligned=0x1234 with eff_sub=1 -> res_mag=0, res_zero=1, res_neg=0, res_lzc=53.
REQ-042 SHALL cover: 4 back-to-back beats with out_ready=0 for 3 cycles -> in_ready drops after 2 accepted beats; all 4 results emerge in order, unchanged.
REQ-043 SHALL cover: rst pulsed with 2 beats in flight -> out_valid=0 next cycle; no stale beat ever appears.
REQ-044 SHALL cover: a random 10k-beat run with random valid/ready against a reference model, both with and without FMA_FINAL_LZC_EN -> zero mismatches.

Source files
------------

// File: rtl/fma_final_add_pkg.sv
// Shared widths and constants for the FMA final-add stage and the multiplier stages.
package fma_final_add_pkg;

  localparam int SIG_WIDTH_DEF = 23;
  localparam int LZC_WIDTH     = 6;
  localparam logic [LZC_WIDTH-1:0] LZC_ZERO = 6'd53;

  // Product/addend datapath width: double-width significand plus guard/alignment bits.
  function automatic int fma_width(input int sig_width);
    return 2 * (sig_width + 1) + 5;
  endfunction

  localparam int FMA_W = fma_width(SIG_WIDTH_DEF);

endpackage

// File: rtl/fma_final_add_lzc.sv
// Combinational leading-zero counter for a 53-bit magnitude; all-zero input yields 53.
module lzc_53
  import fma_final_add_pkg::*;
(
  input  logic [52:0]          din,
  output logic [LZC_WIDTH-1:0] cnt
);

  // Ascending scan: the highest set bit is the last to write cnt.
  always_comb begin
    cnt = LZC_ZERO;
    for (int i = 0; i < 53; i++) begin
      if (din[i]) cnt = 6'(52 - i);
    end
  end

endmodule

// File: rtl/fma_final_add.sv
// FMA final add: product carry-save + aligned addend -> sign/magnitude/LZC, 2-cycle valid/ready pipeline.
// Stalls hold both stages; in_ready drops combinationally when full and out_ready=0. LZC under FMA_FINAL_LZC_EN.
module fma_final_add
  import fma_final_add_pkg::*;
#(
  parameter  int SIG_WIDTH = SIG_WIDTH_DEF,
  localparam int W         = fma_width(SIG_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         pp_sum,
  input  logic [W-1:0]         pp_carry,
  input  logic [W-1:0]         add_aligned,
  input  logic                 eff_sub,
  input  logic                 in_sticky,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         res_mag,
  output logic                 res_neg,
  output logic                 res_zero,
  output logic [LZC_WIDTH-1:0] res_lzc,
  output logic                 out_sticky
);

  logic         s1_valid, s2_valid, s1_advance;
  logic [W-1:0] prod;
  logic [W:0]   csa_x, csa_y, csa_z, csa_maj, csa_sum, csa_carry;
  logic [W:0]   s1_sum, s1_carry;
  logic         s1_sticky;
  logic [W:0]   sum_full;
  logic [W-1:0] mag_d;
  logic         zero_d, neg_d;

  assign s1_advance = !s2_valid || out_ready;
  assign in_ready   = !s1_valid || s1_advance;
  assign out_valid  = s2_valid;

  // Subtraction is ~addend plus a carry-in injected as the third CSA operand.
  always_comb begin
    prod      = pp_sum + pp_carry;
    csa_x     = {1'b0, prod};
    csa_y     = eff_sub ? ~{1'b0, add_aligned} : {1'b0, add_aligned};
    csa_z     = (W + 1)'(eff_sub);
    csa_maj   = (csa_x & csa_y) | (csa_x & csa_z) | (csa_y & csa_z);
    csa_sum   = csa_x ^ csa_y ^ csa_z;
    csa_carry = {csa_maj[W-1:0], 1'b0};
  end

  always_comb begin
    sum_full = s1_sum + s1_carry;
    mag_d    = sum_full[W] ? -sum_full[W-1:0] : sum_full[W-1:0];
    zero_d   = (mag_d == '0);
    neg_d    = sum_full[W] && !zero_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      s1_sum     <= '0;
      s1_carry   <= '0;
      s1_sticky  <= 1'b0;
      res_mag    <= '0;
      res_neg    <= 1'b0;
      res_zero   <= 1'b1;
      out_sticky <= 1'b0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (in_valid && in_ready) begin
        s1_sum    <= csa_sum;
        s1_carry  <= csa_carry;
        s1_sticky <= in_sticky;
      end
      if (s1_advance) s2_valid <= s1_valid;
      if (s1_valid && s1_advance) begin
        res_mag    <= mag_d;
        res_neg    <= neg_d;
        res_zero   <= zero_d;
        out_sticky <= s1_sticky;
      end
    end
  end

`ifdef FMA_FINAL_LZC_EN
  logic [LZC_WIDTH-1:0] lzc_d;

  lzc_53 u_lzc (
    .din (mag_d),
    .cnt (lzc_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      res_lzc <= LZC_ZERO;
    end else if (s1_valid && s1_advance) begin
      res_lzc <= lzc_d;
    end
  end
`else
  assign res_lzc = '0;
`endif

endmodule
